// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch
//   Program-counter sequencer for a small microcoded controller. It steps the
//   PC once per cycle while running. A taken branch loads the PC from an
//   external branch-target table, which is looked up combinationally. A
//   decoded halt parks the sequencer until the next start.
//
//   Build option:
//     REL_BRANCH_EN  defined   -> taken branch: prog_ctr += lut_target
//                                 (lut_target is two's complement)
//                    undefined -> taken branch: prog_ctr  = lut_target
//
//   Parameters:
//     D   program-counter / branch-target width
//     AW  branch-target-table index width
//
//   Ports:
//     clk          in   system clock, rising edge
//     reset        in   synchronous, active-high
//     start        in   begin/restart execution from PC 0 (IDLE/HALTED only)
//     stall        in   freeze PC, state and branch count
//     branch_en    in   taken branch for the current instruction
//     branch_idx   in   branch-target-table index
//     halt         in   decoded halt instruction
//     lut_addr     out  table index (mirrors branch_idx)
//     lut_target   in   table response for lut_addr, same cycle
//     prog_ctr     out  current program counter, registered
//     fetch_valid  out  prog_ctr is a valid fetch address this cycle
//     done         out  halted, registered
//     branch_cnt   out  saturating taken-branch count, registered
// ---------------------------------------------------------------------------
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | out of reset, waiting for start; PC parked at 0
// RUN    | fetching; PC advances or branches unless stalled
// HALTED | halt seen; PC frozen, done high, waiting for start
// ---------------------------------------------------------------------------
module pc_fetch #(
   parameter int D  = 12,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stall,
   input  logic          branch_en,
   input  logic [AW-1:0] branch_idx,
   input  logic          halt,
   output logic [AW-1:0] lut_addr,
   input  logic [D-1:0]  lut_target,
   output logic [D-1:0]  prog_ctr,
   output logic          fetch_valid,
   output logic          done,
   output logic [7:0]    branch_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [D-1:0] PC_ONE = {{(D-1){1'b0}}, 1'b1};
   localparam logic [7:0]   CNT_MAX = 8'hFF;

   state_t       state_q;
   state_t       state_nxt;
   logic [D-1:0] pc_q;
   logic [D-1:0] pc_nxt;
   logic [7:0]   cnt_q;
   logic [7:0]   cnt_nxt;
   logic         done_q;
   logic         done_nxt;
   logic [D-1:0] br_target;

   // The table is addressed straight from the instruction field so that its
   // response is usable in the same cycle.
   assign lut_addr = branch_idx;

`ifdef REL_BRANCH_EN
   // A two's-complement offset added modulo 2^D is an ordinary unsigned add
   // truncated to D bits, so backward branches need no special handling.
   assign br_target = pc_q + lut_target;
`else
   assign br_target = lut_target;
`endif

   always_comb begin
      state_nxt = state_q;
      pc_nxt    = pc_q;
      cnt_nxt   = cnt_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               pc_nxt    = '0;
            end
         end

         RUN: begin
            // stall masks halt and branch_en entirely; start is never
            // honoured here.
            if (!stall) begin
               if (halt) begin
                  state_nxt = HALTED;
               end else if (branch_en) begin
                  pc_nxt = br_target;
                  if (cnt_q != CNT_MAX) begin
                     cnt_nxt = cnt_q + 8'd1;
                  end
               end else begin
                  pc_nxt = pc_q + PC_ONE;
               end
            end
         end

         HALTED: begin
            if (start) begin
               state_nxt = RUN;
               pc_nxt    = '0;
            end
         end

         default: begin
            state_nxt = IDLE;
            pc_nxt    = '0;
         end
      endcase

      // done is registered, so it is derived from the state being entered.
      done_nxt = (state_nxt == HALTED);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         pc_q    <= pc_nxt;
         cnt_q   <= cnt_nxt;
         done_q  <= done_nxt;
      end
   end

   assign prog_ctr    = pc_q;
   assign branch_cnt  = cnt_q;
   assign done        = done_q;
   assign fetch_valid = (state_q == RUN) && !stall;

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

   localparam int D  = 12;
   localparam int AW = 4;
`ifdef REL_BRANCH_EN
   localparam bit REL = 1'b1;
`else
   localparam bit REL = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          start;
   logic          stall;
   logic          branch_en;
   logic [AW-1:0] branch_idx;
   logic          halt;
   logic [AW-1:0] lut_addr;
   logic [D-1:0]  lut_target;
   logic [D-1:0]  prog_ctr;
   logic          fetch_valid;
   logic          done;
   logic [7:0]    branch_cnt;

   int checks = 0;
   int errors = 0;

   pc_fetch #(.D(D), .AW(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stall       (stall),
      .branch_en   (branch_en),
      .branch_idx  (branch_idx),
      .halt        (halt),
      .lut_addr    (lut_addr),
      .lut_target  (lut_target),
      .prog_ctr    (prog_ctr),
      .fetch_valid (fetch_valid),
      .done        (done),
      .branch_cnt  (branch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          st;
      logic          stl;
      logic          br;
      logic [AW-1:0] idx;
      logic          hlt;
      logic [D-1:0]  tgt;
      logic [D-1:0]  e_pc;
      logic          e_valid;
      logic          e_done;
      logic [7:0]    e_cnt;
   } vec_t;

   vec_t tbl [19];

   function automatic vec_t mk(input logic rst, input logic st, input logic stl,
                               input logic br, input logic [AW-1:0] idx,
                               input logic hlt, input logic [D-1:0] tgt,
                               input logic [D-1:0] e_pc, input logic e_valid,
                               input logic e_done, input logic [7:0] e_cnt);
      vec_t v;
      v.rst = rst; v.st = st; v.stl = stl; v.br = br; v.idx = idx;
      v.hlt = hlt; v.tgt = tgt; v.e_pc = e_pc; v.e_valid = e_valid;
      v.e_done = e_done; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit after
   // the rising edge with the same inputs still applied.
   task automatic cyc(input logic rst, input logic st, input logic stl,
                      input logic br, input logic [AW-1:0] idx,
                      input logic hlt, input logic [D-1:0] tgt);
      @(negedge clk);
      reset = rst; start = st; stall = stl; branch_en = br;
      branch_idx = idx; halt = hlt; lut_target = tgt;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step();
      cyc(0, 0, 0, 0, '0, 0, '0);
   endtask

   task automatic reset_start();
      cyc(1, 0, 0, 0, '0, 0, '0);
      cyc(0, 1, 0, 0, '0, 0, '0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stall = 1'b0; branch_en = 1'b0;
      branch_idx = '0; halt = 1'b0; lut_target = '0;

      //            rst st stl br idx hlt tgt       pc                       vld dn cnt
      tbl[0]  = mk(1, 0, 0, 0, 4'd0, 0, 12'd0,   12'd0,                      0, 0, 8'd0);
      tbl[1]  = mk(0, 0, 0, 0, 4'd1, 0, 12'd0,   12'd0,                      0, 0, 8'd0);
      tbl[2]  = mk(0, 0, 0, 1, 4'd3, 1, 12'd5,   12'd0,                      0, 0, 8'd0);
      tbl[3]  = mk(0, 1, 0, 0, 4'd0, 0, 12'd0,   12'd0,                      1, 0, 8'd0);
      tbl[4]  = mk(0, 0, 0, 0, 4'd0, 0, 12'd0,   12'd1,                      1, 0, 8'd0);
      tbl[5]  = mk(0, 0, 0, 0, 4'd0, 0, 12'd0,   12'd2,                      1, 0, 8'd0);
      tbl[6]  = mk(0, 0, 0, 0, 4'd0, 0, 12'd0,   12'd3,                      1, 0, 8'd0);
      tbl[7]  = mk(0, 0, 0, 0, 4'd0, 0, 12'd0,   12'd4,                      1, 0, 8'd0);
      tbl[8]  = mk(0, 0, 0, 1, 4'd2, 0, 12'd20,  REL ? 12'd24 : 12'd20,      1, 0, 8'd1);
      tbl[9]  = mk(0, 0, 0, 1, 4'd15,0, 12'hFFF, REL ? 12'd23 : 12'hFFF,     1, 0, 8'd2);
      tbl[10] = mk(0, 0, 0, 0, 4'd0, 0, 12'd0,   REL ? 12'd24 : 12'd0,       1, 0, 8'd2);
      tbl[11] = mk(0, 1, 1, 1, 4'd7, 1, 12'd99,  REL ? 12'd24 : 12'd0,       0, 0, 8'd2);
      tbl[12] = mk(0, 1, 0, 0, 4'd0, 0, 12'd0,   REL ? 12'd25 : 12'd1,       1, 0, 8'd2);
      tbl[13] = mk(0, 0, 0, 1, 4'd4, 1, 12'd50,  REL ? 12'd25 : 12'd1,       0, 1, 8'd2);
      tbl[14] = mk(0, 0, 0, 0, 4'd0, 0, 12'd0,   REL ? 12'd25 : 12'd1,       0, 1, 8'd2);
      tbl[15] = mk(0, 0, 1, 1, 4'd0, 0, 12'd3,   REL ? 12'd25 : 12'd1,       0, 1, 8'd2);
      tbl[16] = mk(0, 1, 0, 0, 4'd0, 0, 12'd0,   12'd0,                      1, 0, 8'd2);
      tbl[17] = mk(0, 0, 0, 0, 4'd0, 0, 12'd0,   12'd1,                      1, 0, 8'd2);
      tbl[18] = mk(1, 0, 0, 1, 4'd9, 1, 12'd77,  12'd0,                      0, 0, 8'd0);

      for (int i = 0; i < 19; i++) begin
         cyc(tbl[i].rst, tbl[i].st, tbl[i].stl, tbl[i].br, tbl[i].idx,
             tbl[i].hlt, tbl[i].tgt);
         chk($sformatf("vec%0d pc", i),    int'(prog_ctr),    int'(tbl[i].e_pc));
         chk($sformatf("vec%0d valid", i), int'(fetch_valid), int'(tbl[i].e_valid));
         chk($sformatf("vec%0d done", i),  int'(done),        int'(tbl[i].e_done));
         chk($sformatf("vec%0d cnt", i),   int'(branch_cnt),  int'(tbl[i].e_cnt));
         chk($sformatf("vec%0d lut_addr", i), int'(lut_addr), int'(tbl[i].idx));
      end

      // Count 0..5 after start.
      reset_start();
      chk("count pc0", int'(prog_ctr), 0);
      for (int i = 1; i <= 5; i++) begin
         idle_step();
         chk($sformatf("count pc%0d", i), int'(prog_ctr), i);
         chk("count valid", int'(fetch_valid), 1);
         chk("count done", int'(done), 0);
      end

      // Branch by -1 (or absolute to 0xFFF) from PC 4.
      reset_start();
      repeat (4) idle_step();
      chk("pre-branch pc", int'(prog_ctr), 4);
      cyc(0, 0, 0, 1, 4'd1, 0, 12'hFFF);
      chk("branch fff pc", int'(prog_ctr), REL ? 3 : 12'hFFF);
      chk("branch fff cnt", int'(branch_cnt), 1);

      // Branch with target 20 from PC 4.
      reset_start();
      repeat (4) idle_step();
      cyc(0, 0, 0, 1, 4'd2, 0, 12'd20);
      chk("branch 20 pc", int'(prog_ctr), REL ? 24 : 20);
      chk("branch 20 cnt", int'(branch_cnt), 1);

      // Wrap: from 4095 an ordinary step gives 0; from 4090 a +10 branch gives 4.
      reset_start();
      cyc(0, 0, 0, 1, 4'd0, 0, 12'd4095);
      chk("to 4095", int'(prog_ctr), 4095);
      idle_step();
      chk("wrap step", int'(prog_ctr), 0);
      cyc(0, 0, 0, 1, 4'd0, 0, 12'd4090);
      chk("to 4090", int'(prog_ctr), 4090);
      cyc(0, 0, 0, 1, 4'd0, 0, 12'd10);
      chk("wrap branch", int'(prog_ctr), REL ? 4 : 10);

      // Stall masks branch and halt at PC 9.
      reset_start();
      repeat (9) idle_step();
      cyc(0, 0, 1, 1, 4'd5, 1, 12'd100);
      chk("stall pc", int'(prog_ctr), 9);
      chk("stall cnt", int'(branch_cnt), 0);
      chk("stall valid", int'(fetch_valid), 0);
      chk("stall done", int'(done), 0);
      idle_step();
      chk("post-stall pc", int'(prog_ctr), 10);
      chk("post-stall valid", int'(fetch_valid), 1);

      // Halt wins over branch at PC 7, then restart.
      reset_start();
      repeat (7) idle_step();
      cyc(0, 0, 0, 1, 4'd6, 1, 12'd200);
      chk("halt pc", int'(prog_ctr), 7);
      chk("halt done", int'(done), 1);
      chk("halt cnt", int'(branch_cnt), 0);
      chk("halt valid", int'(fetch_valid), 0);
      cyc(0, 1, 0, 0, 4'd0, 0, 12'd0);
      chk("restart pc", int'(prog_ctr), 0);
      chk("restart done", int'(done), 0);
      chk("restart valid", int'(fetch_valid), 1);

      // Saturation over 300 taken branches (target 0 keeps PC at 0 either way).
      reset_start();
      for (int i = 1; i <= 300; i++) begin
         cyc(0, 0, 0, 1, 4'd0, 0, 12'd0);
         if (i == 254 || i == 255 || i == 256 || i == 300) begin
            chk($sformatf("sat cnt after %0d", i), int'(branch_cnt), (i < 255) ? i : 255);
         end
      end
      chk("sat pc", int'(prog_ctr), 0);

      // Reset mid-run with a branch pending.
      cyc(1, 0, 0, 1, 4'd3, 0, 12'd55);
      chk("mid reset pc", int'(prog_ctr), 0);
      chk("mid reset cnt", int'(branch_cnt), 0);
      chk("mid reset valid", int'(fetch_valid), 0);
      chk("mid reset done", int'(done), 0);
      idle_step();
      chk("idle after reset pc", int'(prog_ctr), 0);
      chk("idle after reset valid", int'(fetch_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
